// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/forwarding controller.
// Holds the forward-select encodings, the PC register index and the multiply FSM states.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_RF = 2'b00;
    localparam logic [1:0] FWD_W  = 2'b01;
    localparam logic [1:0] FWD_M  = 2'b10;

    localparam logic [3:0] R_PC = 4'hF;

    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} hc_state_t;

    // The PC is produced by the fetch path, so a source of R15 always reads the register file.
    function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                           input logic [3:0] wa_m, input logic we_m,
                                           input logic [3:0] wa_w, input logic we_w);
        if (ra == R_PC)            return FWD_RF;
        if (we_m && (ra == wa_m))  return FWD_M;
        if (we_w && (ra == wa_w))  return FWD_W;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Bundle between the pipeline datapath and the hazard controller.
// The pipeline (master) drives stage register indices and qualifiers; the controller returns stalls, flushes and forward selects.
interface hazard_ctrl_if #(parameter int CNT_W = 16) ();

    logic [3:0]       RA1D, RA2D, RA1E, RA2E;
    logic [3:0]       WA3E, WA3M, WA3W;
    logic             RegWriteM, RegWriteW, MemtoRegE;
    logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW;
    logic             BranchTakenE, MulStartE, ClrCount;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE;
    logic             FlushD, FlushE, FlushM, MulDoneE;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE, ClrCount,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MulDoneE, StallCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE,
               PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE, MulStartE, ClrCount,
        output ForwardAE, ForwardBE, StallF, StallD, StallE,
               FlushD, FlushE, FlushM, MulDoneE, StallCount
    );

endinterface

// File: rtl/hazard_ctrl_stall_counter.sv
// Saturating event counter with synchronous clear; count visible one cycle after the event.
// Clear wins over a same-cycle increment; the count sticks at all-ones.
module stall_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clr)
            count_d = '0;
        else if (inc && (count_q != '1))
            count_d = count_q + 1'b1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard/forwarding controller for the 5-stage pipeline: stall/flush enables, E-stage forward selects, multiply sequencing.
// All controls are combinational in the current cycle; a multiply holds F/D/E for MUL_LAT-1 cycles.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int MUL_LAT = 3,
    parameter int CNT_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave bus
);

    localparam int              CW       = $clog2(MUL_LAT) + 1;
    localparam logic [CW-1:0]   CNT_LOAD = CW'((MUL_LAT > 1) ? (MUL_LAT - 2) : 0);

    hc_state_t        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             mul_stall, mul_done;
    logic             ldr_stall, pc_wr_pend;
    logic             stall_f;
    logic [CNT_W-1:0] stall_cnt;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mul_stall = 1'b0;
        mul_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.MulStartE) begin
                    if (MUL_LAT == 1) begin
                        mul_done = 1'b1;
                    end else begin
                        mul_stall = 1'b1;
                        cnt_d     = CNT_LOAD;
                        state_d   = BUSY;
                    end
                end
            end
            BUSY: begin
                // The multiply leaves E on the edge that ends the done cycle.
                if (cnt_q != '0) begin
                    mul_stall = 1'b1;
                    cnt_d     = cnt_q - 1'b1;
                end else begin
                    mul_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ldr_stall  = bus.MemtoRegE & ((bus.RA1D == bus.WA3E) | (bus.RA2D == bus.WA3E));
    assign pc_wr_pend = bus.PCSrcD | bus.PCSrcE | bus.PCSrcM;
    assign stall_f    = ldr_stall | pc_wr_pend | mul_stall;

    stall_counter #(.CNT_W(CNT_W)) u_stall_counter (
        .clk   (clk),
        .reset (reset),
        .inc   (stall_f),
        .clr   (bus.ClrCount),
        .count (stall_cnt)
    );

    // Every output reads as idle while reset is held, independent of the inputs.
    assign bus.ForwardAE  = reset ? fwd_sel(bus.RA1E, bus.WA3M, bus.RegWriteM, bus.WA3W, bus.RegWriteW) : FWD_RF;
    assign bus.ForwardBE  = reset ? fwd_sel(bus.RA2E, bus.WA3M, bus.RegWriteM, bus.WA3W, bus.RegWriteW) : FWD_RF;
    assign bus.StallF     = reset & stall_f;
    assign bus.StallD     = reset & (ldr_stall | mul_stall);
    assign bus.StallE     = reset & mul_stall;
    assign bus.FlushD     = reset & (pc_wr_pend | bus.PCSrcW | bus.BranchTakenE);
    assign bus.FlushE     = reset & (ldr_stall | bus.BranchTakenE) & ~mul_stall;
    assign bus.FlushM     = reset & mul_stall;
    assign bus.MulDoneE   = reset & mul_done;
    assign bus.StallCount = reset ? stall_cnt : '0;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: three instances (MUL_LAT 3/4/1) share one stimulus set, each with its own reset.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_a, rst_b, rst_c;
    logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
    logic rwm, rww, m2r, pcd, pce, pcm, pcw, bte, mul, clr;
    int nv = 0;
    int nerr = 0;

    hazard_ctrl_if #(.CNT_W(4))  if_a ();
    hazard_ctrl_if #(.CNT_W(16)) if_b ();
    hazard_ctrl_if #(.CNT_W(8))  if_c ();

    hazard_ctrl #(.MUL_LAT(3), .CNT_W(4))  dut_a (.clk(clk), .reset(rst_a), .bus(if_a));
    hazard_ctrl #(.MUL_LAT(4), .CNT_W(16)) dut_b (.clk(clk), .reset(rst_b), .bus(if_b));
    hazard_ctrl #(.MUL_LAT(1), .CNT_W(8))  dut_c (.clk(clk), .reset(rst_c), .bus(if_c));

    assign {if_a.RA1D, if_b.RA1D, if_c.RA1D} = {3{ra1d}};
    assign {if_a.RA2D, if_b.RA2D, if_c.RA2D} = {3{ra2d}};
    assign {if_a.RA1E, if_b.RA1E, if_c.RA1E} = {3{ra1e}};
    assign {if_a.RA2E, if_b.RA2E, if_c.RA2E} = {3{ra2e}};
    assign {if_a.WA3E, if_b.WA3E, if_c.WA3E} = {3{wa3e}};
    assign {if_a.WA3M, if_b.WA3M, if_c.WA3M} = {3{wa3m}};
    assign {if_a.WA3W, if_b.WA3W, if_c.WA3W} = {3{wa3w}};
    assign {if_a.RegWriteM, if_b.RegWriteM, if_c.RegWriteM} = {3{rwm}};
    assign {if_a.RegWriteW, if_b.RegWriteW, if_c.RegWriteW} = {3{rww}};
    assign {if_a.MemtoRegE, if_b.MemtoRegE, if_c.MemtoRegE} = {3{m2r}};
    assign {if_a.PCSrcD, if_b.PCSrcD, if_c.PCSrcD} = {3{pcd}};
    assign {if_a.PCSrcE, if_b.PCSrcE, if_c.PCSrcE} = {3{pce}};
    assign {if_a.PCSrcM, if_b.PCSrcM, if_c.PCSrcM} = {3{pcm}};
    assign {if_a.PCSrcW, if_b.PCSrcW, if_c.PCSrcW} = {3{pcw}};
    assign {if_a.BranchTakenE, if_b.BranchTakenE, if_c.BranchTakenE} = {3{bte}};
    assign {if_a.MulStartE, if_b.MulStartE, if_c.MulStartE} = {3{mul}};
    assign {if_a.ClrCount, if_b.ClrCount, if_c.ClrCount} = {3{clr}};

    // Packed view {StallF, StallD, StallE, FlushD, FlushE, FlushM, MulDoneE}
    function automatic logic [6:0] outs_a();
        return {if_a.StallF, if_a.StallD, if_a.StallE, if_a.FlushD, if_a.FlushE, if_a.FlushM, if_a.MulDoneE};
    endfunction
    function automatic logic [6:0] outs_b();
        return {if_b.StallF, if_b.StallD, if_b.StallE, if_b.FlushD, if_b.FlushE, if_b.FlushM, if_b.MulDoneE};
    endfunction
    function automatic logic [6:0] outs_c();
        return {if_c.StallF, if_c.StallD, if_c.StallE, if_c.FlushD, if_c.FlushE, if_c.FlushM, if_c.MulDoneE};
    endfunction

    task automatic idle();
        {ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w} = '0;
        {rwm, rww, m2r, pcd, pce, pcm, pcw, bte, mul, clr} = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        ra1e = 4'd3; wa3m = 4'd3; rwm = 1'b1; m2r = 1'b1; pcd = 1'b1; bte = 1'b1; mul = 1'b1;
        #2;
        nv++; if (outs_a() !== 7'b0) begin nerr++; $display("FAIL rst_outs_a: got %b want %b", outs_a(), 7'b0); end
        nv++; if (outs_b() !== 7'b0) begin nerr++; $display("FAIL rst_outs_b: got %b want %b", outs_b(), 7'b0); end
        nv++; if (outs_c() !== 7'b0) begin nerr++; $display("FAIL rst_outs_c: got %b want %b", outs_c(), 7'b0); end
        nv++; if (if_a.ForwardAE !== FWD_RF) begin nerr++; $display("FAIL rst_fwd_a: got %b want %b", if_a.ForwardAE, FWD_RF); end
        step(); step();
        nv++; if (outs_a() !== 7'b0) begin nerr++; $display("FAIL rst_held_a: got %b want %b", outs_a(), 7'b0); end
        nv++; if (if_a.StallCount !== 4'd0) begin nerr++; $display("FAIL rst_cnt_a: got %0d want 0", if_a.StallCount); end
        idle();
        rst_a = 1'b1;
        #1;
        nv++; if (outs_a() !== 7'b0) begin nerr++; $display("FAIL post_rst_a: got %b want %b", outs_a(), 7'b0); end
    endtask

    task automatic test_forwarding();
        wa3m = 4'd3; rwm = 1'b1; wa3w = 4'd3; rww = 1'b1; ra1e = 4'd3; ra2e = 4'd7;
        #1;
        nv++; if (if_a.ForwardAE !== 2'b10) begin nerr++; $display("FAIL fwd_m_prio: got %b want 10", if_a.ForwardAE); end
        nv++; if (if_a.ForwardBE !== 2'b00) begin nerr++; $display("FAIL fwd_b_none: got %b want 00", if_a.ForwardBE); end
        rwm = 1'b0;
        #1;
        nv++; if (if_a.ForwardAE !== 2'b01) begin nerr++; $display("FAIL fwd_w: got %b want 01", if_a.ForwardAE); end
        ra1e = 4'd15; wa3m = 4'd15; wa3w = 4'd15; rwm = 1'b1;
        #1;
        nv++; if (if_a.ForwardAE !== 2'b00) begin nerr++; $display("FAIL fwd_r15: got %b want 00", if_a.ForwardAE); end
        ra1e = 4'd2; ra2e = 4'd9; wa3m = 4'd9; wa3w = 4'd2;
        #1;
        nv++; if (if_a.ForwardAE !== 2'b01) begin nerr++; $display("FAIL fwd_ab_a: got %b want 01", if_a.ForwardAE); end
        nv++; if (if_a.ForwardBE !== 2'b10) begin nerr++; $display("FAIL fwd_ab_b: got %b want 10", if_a.ForwardBE); end
        nv++; if (outs_a() !== 7'b0) begin nerr++; $display("FAIL fwd_no_stall: got %b want %b", outs_a(), 7'b0); end
        idle();
    endtask

    task automatic test_load_use();
        step();
        m2r = 1'b1; wa3e = 4'd5; ra2d = 4'd5;
        #1;
        nv++; if (outs_a() !== 7'b1100100) begin nerr++; $display("FAIL ldr_use: got %b want %b", outs_a(), 7'b1100100); end
        step();
        m2r = 1'b1; wa3e = 4'd6; ra1d = 4'd6; ra2d = 4'd0; pcd = 1'b1;
        #1;
        nv++; if (if_a.StallCount !== 4'd1) begin nerr++; $display("FAIL ldr_cnt1: got %0d want 1", if_a.StallCount); end
        nv++; if (outs_a() !== 7'b1101100) begin nerr++; $display("FAIL ldr_and_pc: got %b want %b", outs_a(), 7'b1101100); end
        step();
        idle();
        #1;
        nv++; if (outs_a() !== 7'b0) begin nerr++; $display("FAIL ldr_clear: got %b want %b", outs_a(), 7'b0); end
        nv++; if (if_a.StallCount !== 4'd2) begin nerr++; $display("FAIL ldr_cnt2: got %0d want 2", if_a.StallCount); end
    endtask

    task automatic test_multiply();
        mul = 1'b1; m2r = 1'b1; wa3e = 4'd5; ra1d = 4'd5;
        #1;
        nv++; if (outs_a() !== 7'b1110010) begin nerr++; $display("FAIL mul_c0_with_ldr: got %b want %b", outs_a(), 7'b1110010); end
        step();
        m2r = 1'b0; wa3e = 4'd0; ra1d = 4'd0;
        #1;
        nv++; if (outs_a() !== 7'b1110010) begin nerr++; $display("FAIL mul_c1: got %b want %b", outs_a(), 7'b1110010); end
        step();
        nv++; if (outs_a() !== 7'b0000001) begin nerr++; $display("FAIL mul_done: got %b want %b", outs_a(), 7'b0000001); end
        step();
        mul = 1'b0;
        #1;
        nv++; if (outs_a() !== 7'b0) begin nerr++; $display("FAIL mul_idle: got %b want %b", outs_a(), 7'b0); end
        nv++; if (if_a.StallCount !== 4'd4) begin nerr++; $display("FAIL mul_cnt: got %0d want 4", if_a.StallCount); end
    endtask

    task automatic test_branch();
        logic [6:0] exp_v [5];
        exp_v[0] = 7'b1001000; exp_v[1] = 7'b1001000; exp_v[2] = 7'b1001000;
        exp_v[3] = 7'b0001000; exp_v[4] = 7'b0001100;
        for (int i = 0; i < 5; i++) begin
            idle();
            case (i)
                0: pcd = 1'b1;
                1: pce = 1'b1;
                2: pcm = 1'b1;
                3: pcw = 1'b1;
                default: bte = 1'b1;
            endcase
            #1;
            nv++; if (outs_a() !== exp_v[i]) begin nerr++; $display("FAIL branch_c%0d: got %b want %b", i, outs_a(), exp_v[i]); end
            step();
        end
        idle();
        #1;
        nv++; if (if_a.StallCount !== 4'd7) begin nerr++; $display("FAIL branch_cnt: got %0d want 7", if_a.StallCount); end
    endtask

    task automatic test_counter();
        pcd = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            if (i == 6) begin
                nv++; if (if_a.StallCount !== 4'd14) begin nerr++; $display("FAIL cnt_14: got %0d want 14", if_a.StallCount); end
            end
        end
        nv++; if (if_a.StallCount !== 4'd15) begin nerr++; $display("FAIL cnt_sat: got %0d want 15", if_a.StallCount); end
        clr = 1'b1;
        step();
        clr = 1'b0;
        #1;
        nv++; if (if_a.StallCount !== 4'd0) begin nerr++; $display("FAIL cnt_clr_prio: got %0d want 0", if_a.StallCount); end
        step();
        nv++; if (if_a.StallCount !== 4'd1) begin nerr++; $display("FAIL cnt_after_clr: got %0d want 1", if_a.StallCount); end
        idle();
    endtask

    task automatic test_mul_lat1();
        rst_c = 1'b1;
        mul = 1'b1;
        #1;
        nv++; if (outs_c() !== 7'b0000001) begin nerr++; $display("FAIL lat1_done: got %b want %b", outs_c(), 7'b0000001); end
        step();
        mul = 1'b0;
        #1;
        nv++; if (outs_c() !== 7'b0) begin nerr++; $display("FAIL lat1_idle: got %b want %b", outs_c(), 7'b0); end
        nv++; if (if_c.StallCount !== 8'd0) begin nerr++; $display("FAIL lat1_cnt: got %0d want 0", if_c.StallCount); end
    endtask

    task automatic test_reset_mid_mul();
        rst_b = 1'b1;
        mul = 1'b1;
        #1;
        nv++; if (outs_b() !== 7'b1110010) begin nerr++; $display("FAIL rmm_c0: got %b want %b", outs_b(), 7'b1110010); end
        step();
        ra1e = 4'd3; wa3m = 4'd3; rwm = 1'b1;
        #1;
        nv++; if (outs_b() !== 7'b1110010) begin nerr++; $display("FAIL rmm_c1: got %b want %b", outs_b(), 7'b1110010); end
        nv++; if (if_b.StallCount !== 16'd1) begin nerr++; $display("FAIL rmm_cnt1: got %0d want 1", if_b.StallCount); end
        rst_b = 1'b0;
        #1;
        nv++; if (outs_b() !== 7'b0) begin nerr++; $display("FAIL rmm_async: got %b want %b", outs_b(), 7'b0); end
        nv++; if (if_b.ForwardAE !== FWD_RF) begin nerr++; $display("FAIL rmm_fwd: got %b want %b", if_b.ForwardAE, FWD_RF); end
        nv++; if (if_b.StallCount !== 16'd0) begin nerr++; $display("FAIL rmm_cnt0: got %0d want 0", if_b.StallCount); end
        step();
        idle();
        rst_b = 1'b1;
        #1;
        nv++; if (outs_b() !== 7'b0) begin nerr++; $display("FAIL rmm_release: got %b want %b", outs_b(), 7'b0); end
        step();
        nv++; if (outs_b() !== 7'b0) begin nerr++; $display("FAIL rmm_no_stall: got %b want %b", outs_b(), 7'b0); end
        mul = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            nv++; if (outs_b() !== 7'b1110010) begin nerr++; $display("FAIL lat4_stall_c%0d: got %b want %b", i, outs_b(), 7'b1110010); end
            step();
        end
        nv++; if (outs_b() !== 7'b0000001) begin nerr++; $display("FAIL lat4_done: got %b want %b", outs_b(), 7'b0000001); end
        step();
        mul = 1'b0;
        #1;
        nv++; if (outs_b() !== 7'b0) begin nerr++; $display("FAIL lat4_idle: got %b want %b", outs_b(), 7'b0); end
    endtask

    initial begin
        test_reset();
        test_forwarding();
        test_load_use();
        test_multiply();
        test_branch();
        test_counter();
        test_mul_lat1();
        test_reset_mid_mul();
        $display("== %0d vectors applied, %0d miscompares ==", nv, nerr);
        $finish;
    end

endmodule
